// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises 10-bit commands as one SS_n-low frame and returns the
// 8-bit MISO reply for read-data commands. The SPI bit rate equals clk.
module spi_master_ctrl #(
    parameter int RD_GAP   = 1,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_word,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    // state  | meaning
    // IDLE   | ready for a command
    // START  | SS_n low, MOSI = cmd[9]
    // SHIFT  | cmd[9]..cmd[0] on MOSI, count 9 down to 0
    // WAIT   | read-data turnaround, MOSI = 0
    // RECV   | 8 MISO bits shifted into rsp_data
    // END    | SS_n high, rsp_valid for read-data frames
    // GAP    | extra SS_n-high cycles before IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SHIFT, S_WAIT, S_RECV, S_END, S_GAP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_GAP - 1);
    // END and the IDLE handshake cycle both count towards the high gap.
    localparam bit         HAS_GAP   = (IDLE_GAP > 2);
    localparam logic [3:0] GAP_LOAD  = HAS_GAP ? 4'(IDLE_GAP - 3) : 4'd0;

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [9:0] cmd_q;
    logic       is_rd;
    logic       ss_n_d, mosi_d, rsp_valid_d;

    assign is_rd     = (cmd_q[9:8] == 2'b11);
    assign cmd_ready = (state == S_IDLE) && rst_n;
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE:  if (cmd_valid) state_d = S_START;
            S_START: begin
                state_d = S_SHIFT;
                cnt_d   = 4'd9;
            end
            S_SHIFT: begin
                if (cnt == 4'd0) begin
                    if (is_rd) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_END;
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = S_RECV;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RECV: begin
                if (cnt == 4'd0) state_d = S_END;
                else             cnt_d   = cnt - 4'd1;
            end
            S_END: begin
                if (HAS_GAP) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt == 4'd0) state_d = S_IDLE;
                else             cnt_d   = cnt - 4'd1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pin values are decoded from the next state so they leave a flop directly.
    always_comb begin
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_d)
            S_START: begin
                ss_n_d = 1'b0;
                mosi_d = cmd_word[9];
            end
            S_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = cmd_q[cnt_d];
            end
            S_WAIT, S_RECV: ss_n_d = 1'b0;
            S_END:          rsp_valid_d = is_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cmd_q     <= 10'd0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            rsp_valid <= rsp_valid_d;
            if (state == S_IDLE && cmd_valid) cmd_q <= cmd_word;
            if (state == S_RECV) rsp_data <= {rsp_data[6:0], MISO};
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: table vectors, back-to-back and reset corner cases,
// and random frames checked against a frame-level reference model.
module tb_spi_master_ctrl;

    localparam int RD_GAP   = 1;
    localparam int IDLE_GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [9:0] cmd_word;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int total = 0;
    int bad   = 0;
    int rsp_seen = 0;
    int rsp_exp  = 0;
    logic [7:0] last_rsp;
    logic [9:0] hs_cmd = 10'd0;

    spi_master_ctrl #(.RD_GAP(RD_GAP), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rsp_valid) rsp_seen++;
        if (rst_n && cmd_valid && cmd_ready) hs_cmd <= cmd_word;
    end

    a_frame: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(SS_n) |=> (!SS_n) [*10])
        else begin bad++; $display("FAIL sva_frame_low: SS_n rose before 11 low cycles"); end

    a_rd: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (hs_cmd[9:8] == 2'b11))
        else begin bad++; $display("FAIL sva_rsp_rd: rsp_valid for cmd %0h", hs_cmd); end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  cmd;
        logic [7:0]  miso;
        int          len;
        logic        rv;
        logic [7:0]  rsp;
        logic [10:0] mosi;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [9:0] c);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_word  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_word  = 10'($urandom);
    endtask

    // Called at the negedge of the START cycle; returns at the negedge of the END cycle.
    task automatic check_frame(input logic [9:0] c, input logic [7:0] b, input int len,
                               input logic rv, input logic [7:0] rsp,
                               input logic [10:0] mosi11, input bit scramble);
        int rstart = 11 + RD_GAP;
        for (int i = 0; i < len; i++) begin
            chk("ss_low", SS_n, 1'b0);
            chk("mosi", MOSI, (i < 11) ? mosi11[10-i] : 1'b0);
            chk("rsp_valid_mid", rsp_valid, 1'b0);
            chk("busy_mid", busy, 1'b1);
            if (i >= rstart) MISO = b[7-(i-rstart)];
            else             MISO = 1'($urandom);
            if (scramble) begin
                cmd_word  = 10'($urandom);
                cmd_valid = 1'($urandom);
            end
            @(negedge clk);
        end
        if (scramble) cmd_valid = 1'b0;
        chk("ss_end", SS_n, 1'b1);
        chk("mosi_end", MOSI, 1'b0);
        chk("rsp_valid_end", rsp_valid, rv);
        chk("rsp_data", rsp_data, rsp);
        if (rv) rsp_exp++;
        last_rsp = rsp;
    endtask

    task automatic model_frame(input logic [9:0] c, input logic [7:0] b);
        logic rd = (c[9:8] == 2'b11);
        int   len = 11 + (rd ? RD_GAP + 8 : 0);
        check_frame(c, b, len, rd, rd ? b : last_rsp, {c[9], c}, 1'b1);
    endtask

    initial begin
        int gap;
        int n;
        logic [9:0] rc;
        logic [7:0] rb;

        vecs[0] = '{10'b01_1010_0101, 8'h00, 11, 1'b0, 8'h00, 11'b00110100101};
        vecs[1] = '{10'b11_0000_0000, 8'hC3, 20, 1'b1, 8'hC3, 11'b11100000000};
        vecs[2] = '{10'b00_1111_0000, 8'hAA, 11, 1'b0, 8'hC3, 11'b00011110000};
        vecs[3] = '{10'b10_0101_0101, 8'h5A, 11, 1'b0, 8'hC3, 11'b11001010101};
        vecs[4] = '{10'b11_1111_1111, 8'h81, 20, 1'b1, 8'h81, 11'b11111111111};
        vecs[5] = '{10'b11_0101_1010, 8'h00, 20, 1'b1, 8'h00, 11'b11101011010};
        vecs[6] = '{10'b01_0000_0001, 8'hFF, 11, 1'b0, 8'h00, 11'b00100000001};

        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_word  = 10'h3FF;
        MISO      = 1'b1;
        last_rsp  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ss", SS_n, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1'b1);
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(vecs[k].cmd);
            check_frame(vecs[k].cmd, vecs[k].miso, vecs[k].len, vecs[k].rv,
                        vecs[k].rsp, vecs[k].mosi, 1'b1);
        end

        // Back-to-back with cmd_valid held high; second word presented mid-frame.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_word  = 10'b01_1100_0011;
        @(negedge clk);
        cmd_word  = 10'b00_0110_1001;
        check_frame(10'b01_1100_0011, 8'h00, 11, 1'b0, last_rsp, 11'b00111000011, 1'b0);
        gap = 1;
        n   = 0;
        @(negedge clk);
        while (SS_n && n < 20) begin
            gap++;
            n++;
            @(negedge clk);
        end
        chk("b2b_gap", gap, IDLE_GAP);
        cmd_valid = 1'b0;
        cmd_word  = 10'($urandom);
        check_frame(10'b00_0110_1001, 8'h00, 11, 1'b0, last_rsp, 11'b00001101001, 1'b1);

        // Async reset in the middle of a read-data frame.
        issue(10'b11_1010_1010);
        for (int i = 0; i < 6; i++) begin
            chk("pre_rst_ss", SS_n, 1'b0);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ss", SS_n, 1'b1);
        chk("midrst_mosi", MOSI, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        last_rsp = 8'h00;
        repeat (25) @(negedge clk);
        chk("midrst_no_rsp", rsp_seen, rsp_exp);
        chk("midrst_rsp_data", rsp_data, 8'h00);
        issue(10'b11_0011_1100);
        check_frame(10'b11_0011_1100, 8'h96, 20, 1'b1, 8'h96, 11'b11100111100, 1'b1);

        for (int k = 0; k < 25; k++) begin
            rc = 10'($urandom);
            if (k % 3 == 0) rc[9:8] = 2'b11;
            rb = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(rc);
            model_frame(rc, rb);
        end

        repeat (5) @(negedge clk);
        chk("rsp_pulse_count", rsp_seen, rsp_exp);
        chk("idle_ss", SS_n, 1'b1);
        chk("idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
